// File: rtl/dds_param_regs.sv
// PicoRV32 memory-mapped parameter bank for the dual-channel DDS.
// Software writes shadow registers; a commit copies them to the active outputs in one edge.
module dds_param_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter logic [31:0] F_WORD_RST = 32'd343597
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        apply_stb,
  output logic [31:0] f_word_A,
  output logic [31:0] f_word_B,
  output logic [13:0] dds_phase_A,
  output logic [13:0] dds_phase_B,
  output logic [4:0]  amplitude_A,
  output logic [4:0]  amplitude_B,
  output logic [2:0]  wave_A,
  output logic [2:0]  wave_B,
  output logic [7:0]  duty_cycle_A,
  output logic [7:0]  duty_cycle_B,
  output logic [31:0] div_fractor_A,
  output logic [31:0] div_fractor_B,
  output logic [13:0] vol_bias_A,
  output logic [13:0] vol_bias_B,
  output logic        dds_choose_en_A,
  output logic        dds_choose_en_B,
  output logic [1:0]  dds_pwm_choose
);

  typedef struct packed {
    logic [31:0] f_a;
    logic [31:0] f_b;
    logic [13:0] ph_a;
    logic [13:0] ph_b;
    logic [4:0]  amp_a;
    logic [4:0]  amp_b;
    logic [2:0]  wave_a;
    logic [2:0]  wave_b;
    logic [7:0]  duty_a;
    logic [7:0]  duty_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [13:0] bias_a;
    logic [13:0] bias_b;
    logic        en_a;
    logic        en_b;
    logic [1:0]  pwm;
  } params_t;

  localparam params_t PARAMS_RST = '{
    f_a: F_WORD_RST, f_b: F_WORD_RST, ph_a: '0, ph_b: '0,
    amp_a: 5'd1, amp_b: 5'd1, wave_a: '0, wave_b: '0,
    duty_a: 8'd25, duty_b: 8'd25, div_a: 32'd10000, div_b: 32'd10000,
    bias_a: '0, bias_b: '0, en_a: 1'b1, en_b: 1'b1, pwm: '0
  };

  params_t     shadow, sh_nxt, active;
  logic        sync_mode, sync_nxt, pending;
  logic [15:0] commit_cnt;
  logic [5:0]  idx;
  logic        hit, accept, wr, rd, commit, apply;
  logic [31:0] rword, merged;
  logic        unused_addr_bits;

  assign idx              = mem_addr[7:2];
  assign unused_addr_bits = ^mem_addr[1:0];
  assign hit    = (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign accept = mem_valid && hit && !mem_ready;
  assign wr     = accept && (mem_wstrb != 4'b0000);
  assign rd     = accept && (mem_wstrb == 4'b0000);
  assign commit = wr && (idx == 6'd9) && mem_wstrb[0] && mem_wdata[0];
  assign apply  = pending && (!sync_mode || apply_stb);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    rword = '0;
    case (idx)
      6'd0: rword = shadow.f_a;
      6'd1: rword = shadow.f_b;
      6'd2: rword = {2'b0, shadow.ph_b, 2'b0, shadow.ph_a};
      6'd3: rword = {5'b0, shadow.wave_b, 3'b0, shadow.amp_b,
                     5'b0, shadow.wave_a, 3'b0, shadow.amp_a};
      6'd4: rword = {16'b0, shadow.duty_b, shadow.duty_a};
      6'd5: rword = shadow.div_a;
      6'd6: rword = shadow.div_b;
      6'd7: rword = {2'b0, shadow.bias_b, 2'b0, shadow.bias_a};
      6'd8: rword = {27'b0, sync_mode, shadow.pwm, shadow.en_b, shadow.en_a};
      6'd9: rword = {commit_cnt, 15'b0, pending};
      default: rword = '0;
    endcase
  end

  // Byte-strobe merge reuses the readback word so unimplemented bits stay zero.
  assign merged = merge_bytes(rword, mem_wdata, mem_wstrb);

  always_comb begin
    sh_nxt   = shadow;
    sync_nxt = sync_mode;
    if (wr) begin
      case (idx)
        6'd0: sh_nxt.f_a = merged;
        6'd1: sh_nxt.f_b = merged;
        6'd2: begin
          sh_nxt.ph_a = merged[13:0];
          sh_nxt.ph_b = merged[29:16];
        end
        6'd3: begin
          sh_nxt.amp_a  = merged[4:0];
          sh_nxt.wave_a = merged[10:8];
          sh_nxt.amp_b  = merged[20:16];
          sh_nxt.wave_b = merged[26:24];
        end
        6'd4: begin
          sh_nxt.duty_a = merged[7:0];
          sh_nxt.duty_b = merged[15:8];
        end
        6'd5: sh_nxt.div_a = merged;
        6'd6: sh_nxt.div_b = merged;
        6'd7: begin
          sh_nxt.bias_a = merged[13:0];
          sh_nxt.bias_b = merged[29:16];
        end
        6'd8: begin
          sh_nxt.en_a = merged[0];
          sh_nxt.en_b = merged[1];
          sh_nxt.pwm  = merged[3:2];
          sync_nxt    = merged[4];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= PARAMS_RST;
      active     <= PARAMS_RST;
      sync_mode  <= 1'b0;
      pending    <= 1'b0;
      commit_cnt <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= rd ? rword : '0;
      shadow    <= sh_nxt;
      sync_mode <= sync_nxt;
      // Active takes the pre-write shadow; a same-edge COMMIT re-arms pending.
      if (apply) begin
        active     <= shadow;
        commit_cnt <= commit_cnt + 16'd1;
      end
      if (commit)     pending <= 1'b1;
      else if (apply) pending <= 1'b0;
    end
  end

  assign f_word_A        = active.f_a;
  assign f_word_B        = active.f_b;
  assign dds_phase_A     = active.ph_a;
  assign dds_phase_B     = active.ph_b;
  assign amplitude_A     = active.amp_a;
  assign amplitude_B     = active.amp_b;
  assign wave_A          = active.wave_a;
  assign wave_B          = active.wave_b;
  assign duty_cycle_A    = active.duty_a;
  assign duty_cycle_B    = active.duty_b;
  assign div_fractor_A   = active.div_a;
  assign div_fractor_B   = active.div_b;
  assign vol_bias_A      = active.bias_a;
  assign vol_bias_B      = active.bias_b;
  assign dds_choose_en_A = active.en_a;
  assign dds_choose_en_B = active.en_b;
  assign dds_pwm_choose  = active.pwm;

endmodule
